// File: rtl/rv32_opcodes_pkg.sv
// rv32_opcodes: shared RV32I decode definitions.
//   - base opcode and funct3 constants
//   - ALU operation and branch condition enums consumed by execute
//   - memory access width constants (equal to funct3[1:0] of loads/stores)
//   - ctrl_t: the registered control bundle of the decode stage
//   - alu_from_funct3(): maps OP/OP-IMM funct3 plus the funct7[5] bit to an ALU op
package rv32_opcodes;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_SRC2 = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        BR_NEVER    = 2'd0,
        BR_ALWAYS   = 2'd1,
        BR_ZERO     = 2'd2,
        BR_NON_ZERO = 2'd3
    } branch_op_t;

    // All-zero value is the bubble: ALU_ADD, BR_NEVER, no side effects.
    typedef struct packed {
        alu_op_t    alu_op;
        logic       alu_src1;
        logic       alu_src2;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_width;
        logic       mem_zero_extend;
        branch_op_t branch_op;
        logic       rd_write;
        logic       illegal;
    } ctrl_t;

    function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32_regs.sv
// rv32_regs: 31 x 32-bit integer register file (x1..x31), x0 hardwired to 0.
//   clk         in   clock
//   wr_en_i     in   write enable from writeback
//   wr_idx_i    in   write register index (writes to x0 are dropped)
//   wr_data_i   in   write data
//   rd0_idx_i   in   read port 0 index (rs1)
//   rd1_idx_i   in   read port 1 index (rs2)
//   rd0_data_o  out  read port 0 data, combinational, with write-through
//   rd1_data_o  out  read port 1 data, combinational, with write-through
module rv32_regs (
    input  logic        clk,
    input  logic        wr_en_i,
    input  logic [4:0]  wr_idx_i,
    input  logic [31:0] wr_data_i,
    input  logic [4:0]  rd0_idx_i,
    input  logic [4:0]  rd1_idx_i,
    output logic [31:0] rd0_data_o,
    output logic [31:0] rd1_data_o
);

    // Storage is deliberately not reset; x0 has no storage at all.
    logic [31:0] regs_q [1:31];

    always_ff @(posedge clk) begin
        if (wr_en_i && wr_idx_i != 5'd0) begin
            regs_q[wr_idx_i] <= wr_data_i;
        end
    end

    // A read of the register being written this cycle sees the new value, so
    // decode never latches a stale operand across the writeback edge.
    always_comb begin
        rd0_data_o = '0;
        rd1_data_o = '0;
        if (rd0_idx_i != 5'd0) begin
            rd0_data_o = (wr_en_i && wr_idx_i == rd0_idx_i) ? wr_data_i : regs_q[rd0_idx_i];
        end
        if (rd1_idx_i != 5'd0) begin
            rd1_data_o = (wr_en_i && wr_idx_i == rd1_idx_i) ? wr_data_i : regs_q[rd1_idx_i];
        end
    end

endmodule

// File: rtl/rv32_decode.sv
// rv32_decode: RV32I decode stage (fetch -> decode -> execute).
// Registers {pc, prediction}, decodes instr_in into control fields and a
// sign-extended immediate, and reads rs1/rs2 from the integrated register file.
// All outputs are registered: one cycle from instr_in to the decoded bundle.
//   clk, reset                  clock, synchronous active-high reset
//   stall_in / flush_in         hold / squash the stage (flush wins)
//   pc_in, instr_in,
//   branch_predicted_taken_in   fetched bundle
//   rd_write_in, rd_in,
//   rd_value_in                 register file write port from writeback
//   valid_out ... illegal_out   decoded bundle presented to execute
module rv32_decode
    import rv32_opcodes::*;
#(
    parameter bit RESET_PC_VALID = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        branch_predicted_taken_in,
    input  logic        rd_write_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] rd_value_in,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic        branch_predicted_taken_out,
    output logic [4:0]  rs1_out,
    output logic [4:0]  rs2_out,
    output logic [4:0]  rd_out,
    output logic [31:0] rs1_value_out,
    output logic [31:0] rs2_value_out,
    output logic [31:0] imm_value_out,
    output logic [3:0]  alu_op_out,
    output logic        alu_src1_out,
    output logic        alu_src2_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [1:0]  mem_width_out,
    output logic        mem_zero_extend_out,
    output logic [1:0]  branch_op_out,
    output logic        rd_write_out,
    output logic        illegal_out
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_rdata, rs2_rdata;
    ctrl_t       ctrl_dec;
    logic [31:0] imm_dec;

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic        bpt_q, bpt_d;
    logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [31:0] rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
    logic [31:0] imm_q, imm_d;
    ctrl_t       ctrl_q, ctrl_d;

    assign opcode  = instr_in[6:0];
    assign funct3  = instr_in[14:12];
    assign rd_idx  = instr_in[11:7];
    assign rs1_idx = instr_in[19:15];
    assign rs2_idx = instr_in[24:20];

    assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                    instr_in[11:8], 1'b0};
    assign imm_u = {instr_in[31:12], 12'b0};
    assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                    instr_in[30:21], 1'b0};

    rv32_regs u_regs (
        .clk        (clk),
        .wr_en_i    (rd_write_in),
        .wr_idx_i   (rd_in),
        .wr_data_i  (rd_value_in),
        .rd0_idx_i  (rs1_idx),
        .rd1_idx_i  (rs2_idx),
        .rd0_data_o (rs1_rdata),
        .rd1_data_o (rs2_rdata)
    );

    always_comb begin
        ctrl_dec = '0;
        imm_dec  = '0;
        case (opcode)
            OPC_LUI: begin
                ctrl_dec.alu_op   = ALU_SRC2;
                ctrl_dec.alu_src2 = 1'b1;
                ctrl_dec.rd_write = 1'b1;
                imm_dec           = imm_u;
            end
            OPC_AUIPC: begin
                ctrl_dec.alu_src1 = 1'b1;
                ctrl_dec.alu_src2 = 1'b1;
                ctrl_dec.rd_write = 1'b1;
                imm_dec           = imm_u;
            end
            // Jumps compute the target in the ALU; execute supplies pc+4 for rd.
            OPC_JAL: begin
                ctrl_dec.alu_src1  = 1'b1;
                ctrl_dec.alu_src2  = 1'b1;
                ctrl_dec.branch_op = BR_ALWAYS;
                ctrl_dec.rd_write  = 1'b1;
                imm_dec            = imm_j;
            end
            OPC_JALR: begin
                ctrl_dec.alu_src2  = 1'b1;
                ctrl_dec.branch_op = BR_ALWAYS;
                ctrl_dec.rd_write  = 1'b1;
                imm_dec            = imm_i;
            end
            // Branches compare rs1/rs2 in the ALU and test the result for zero.
            OPC_BRANCH: begin
                imm_dec = imm_b;
                case (funct3)
                    F3_BEQ:  begin ctrl_dec.alu_op = ALU_SUB;  ctrl_dec.branch_op = BR_ZERO;     end
                    F3_BNE:  begin ctrl_dec.alu_op = ALU_SUB;  ctrl_dec.branch_op = BR_NON_ZERO; end
                    F3_BLT:  begin ctrl_dec.alu_op = ALU_SLT;  ctrl_dec.branch_op = BR_NON_ZERO; end
                    F3_BGE:  begin ctrl_dec.alu_op = ALU_SLT;  ctrl_dec.branch_op = BR_ZERO;     end
                    F3_BLTU: begin ctrl_dec.alu_op = ALU_SLTU; ctrl_dec.branch_op = BR_NON_ZERO; end
                    F3_BGEU: begin ctrl_dec.alu_op = ALU_SLTU; ctrl_dec.branch_op = BR_ZERO;     end
                    default: ctrl_dec.illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                ctrl_dec.alu_src2        = 1'b1;
                ctrl_dec.mem_read        = 1'b1;
                ctrl_dec.rd_write        = 1'b1;
                ctrl_dec.mem_width       = funct3[1:0];
                ctrl_dec.mem_zero_extend = funct3[2];
                imm_dec                  = imm_i;
                // Only LB/LH/LW/LBU/LHU exist.
                if (funct3[1:0] == 2'b11 || (funct3[2] && funct3[1:0] == MEM_WORD)) begin
                    ctrl_dec.illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                ctrl_dec.alu_src2  = 1'b1;
                ctrl_dec.mem_write = 1'b1;
                ctrl_dec.mem_width = funct3[1:0];
                imm_dec            = imm_s;
                if (funct3[2] || funct3[1:0] == 2'b11) begin
                    ctrl_dec.illegal = 1'b1;
                end
            end
            // instr[30] is an immediate bit for OP-IMM, so it only selects SRAI.
            OPC_OP_IMM: begin
                ctrl_dec.alu_op   = alu_from_funct3(funct3, instr_in[30] && funct3 == F3_SRL_SRA);
                ctrl_dec.alu_src2 = 1'b1;
                ctrl_dec.rd_write = 1'b1;
                imm_dec           = imm_i;
            end
            OPC_OP: begin
                ctrl_dec.alu_op   = alu_from_funct3(funct3, instr_in[30]);
                ctrl_dec.rd_write = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                // Executed as a NOP.
            end
            default: ctrl_dec.illegal = 1'b1;
        endcase

        if (instr_in[1:0] != 2'b11) begin
            ctrl_dec.illegal = 1'b1;
        end
        if (ctrl_dec.illegal) begin
            ctrl_dec.rd_write  = 1'b0;
            ctrl_dec.mem_read  = 1'b0;
            ctrl_dec.mem_write = 1'b0;
            ctrl_dec.branch_op = BR_NEVER;
        end
        if (rd_idx == 5'd0) begin
            ctrl_dec.rd_write = 1'b0;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        bpt_d     = bpt_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        imm_d     = imm_q;
        ctrl_d    = ctrl_q;
        if (flush_in) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (stall_in) begin
            // Held operands track writeback so the bundle is current on release.
            if (rd_write_in && rd_in != 5'd0 && rd_in == rs1_q) begin
                rs1_val_d = rd_value_in;
            end
            if (rd_write_in && rd_in != 5'd0 && rd_in == rs2_q) begin
                rs2_val_d = rd_value_in;
            end
        end else begin
            valid_d   = 1'b1;
            pc_d      = pc_in;
            bpt_d     = branch_predicted_taken_in;
            rs1_d     = rs1_idx;
            rs2_d     = rs2_idx;
            rd_d      = rd_idx;
            rs1_val_d = rs1_rdata;
            rs2_val_d = rs2_rdata;
            imm_d     = imm_dec;
            ctrl_d    = ctrl_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= RESET_PC_VALID;
            pc_q      <= '0;
            bpt_q     <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            imm_q     <= '0;
            ctrl_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            bpt_q     <= bpt_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            imm_q     <= imm_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign valid_out                  = valid_q;
    assign pc_out                     = pc_q;
    assign branch_predicted_taken_out = bpt_q;
    assign rs1_out                    = rs1_q;
    assign rs2_out                    = rs2_q;
    assign rd_out                     = rd_q;
    assign rs1_value_out              = rs1_val_q;
    assign rs2_value_out              = rs2_val_q;
    assign imm_value_out              = imm_q;
    assign alu_op_out                 = ctrl_q.alu_op;
    assign alu_src1_out               = ctrl_q.alu_src1;
    assign alu_src2_out               = ctrl_q.alu_src2;
    assign mem_read_out               = ctrl_q.mem_read;
    assign mem_write_out              = ctrl_q.mem_write;
    assign mem_width_out              = ctrl_q.mem_width;
    assign mem_zero_extend_out        = ctrl_q.mem_zero_extend;
    assign branch_op_out              = ctrl_q.branch_op;
    assign rd_write_out               = ctrl_q.rd_write;
    assign illegal_out                = ctrl_q.illegal;

endmodule

// File: tb/tb_rv32_decode.sv
// Bench for rv32_decode: a table of instructions with hand-derived expected
// bundles, plus explicit stall/flush sequences. Expectations are queued when
// the stimulus is driven and checked one clock later when the bundle appears.
module tb_rv32_decode;
    import rv32_opcodes::*;

    logic        clk = 1'b0;
    logic        reset, stall_in, flush_in;
    logic [31:0] pc_in, instr_in;
    logic        branch_predicted_taken_in;
    logic        rd_write_in;
    logic [4:0]  rd_in;
    logic [31:0] rd_value_in;
    logic        valid_out, branch_predicted_taken_out;
    logic [31:0] pc_out, rs1_value_out, rs2_value_out, imm_value_out;
    logic [4:0]  rs1_out, rs2_out, rd_out;
    logic [3:0]  alu_op_out;
    logic        alu_src1_out, alu_src2_out, mem_read_out, mem_write_out;
    logic [1:0]  mem_width_out, branch_op_out;
    logic        mem_zero_extend_out, rd_write_out, illegal_out;

    rv32_decode dut (
        .clk                        (clk),
        .reset                      (reset),
        .stall_in                   (stall_in),
        .flush_in                   (flush_in),
        .pc_in                      (pc_in),
        .instr_in                   (instr_in),
        .branch_predicted_taken_in  (branch_predicted_taken_in),
        .rd_write_in                (rd_write_in),
        .rd_in                      (rd_in),
        .rd_value_in                (rd_value_in),
        .valid_out                  (valid_out),
        .pc_out                     (pc_out),
        .branch_predicted_taken_out (branch_predicted_taken_out),
        .rs1_out                    (rs1_out),
        .rs2_out                    (rs2_out),
        .rd_out                     (rd_out),
        .rs1_value_out              (rs1_value_out),
        .rs2_value_out              (rs2_value_out),
        .imm_value_out              (imm_value_out),
        .alu_op_out                 (alu_op_out),
        .alu_src1_out               (alu_src1_out),
        .alu_src2_out               (alu_src2_out),
        .mem_read_out               (mem_read_out),
        .mem_write_out              (mem_write_out),
        .mem_width_out              (mem_width_out),
        .mem_zero_extend_out        (mem_zero_extend_out),
        .branch_op_out              (branch_op_out),
        .rd_write_out               (rd_write_out),
        .illegal_out                (illegal_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        bpt;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rs1v, rs2v, imm;
        logic [3:0]  alu;
        logic        s1, s2, mr, mw;
        logic [1:0]  wid;
        logic        zx;
        logic [1:0]  bop;
        logic        rdw, ill;
        bit          chk_imm, chk_alu, bubble;
    } exp_t;

    typedef struct {
        logic [31:0] instr, pc;
        logic        bpt, wbe;
        logic [4:0]  wrd;
        logic [31:0] wval;
        exp_t        e;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_asrt = 0;
    int   n_fail = 0;

    function automatic exp_t dec(input logic [31:0] pc, input logic bpt,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [31:0] rs1v, input logic [31:0] rs2v, input logic [31:0] imm,
                                 input logic [3:0] alu, input logic s1, input logic s2, input logic rdw);
        exp_t e;
        e = '{default: '0};
        e.valid = 1'b1; e.pc = pc; e.bpt = bpt;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.rs1v = rs1v; e.rs2v = rs2v; e.imm = imm;
        e.alu = alu; e.s1 = s1; e.s2 = s2; e.rdw = rdw;
        e.chk_imm = 1'b1; e.chk_alu = 1'b1;
        return e;
    endfunction

    task automatic add(input logic [31:0] instr, input logic [31:0] pc, input logic bpt,
                       input logic wbe, input logic [4:0] wrd, input logic [31:0] wval, input exp_t e);
        vec_t v;
        v.instr = instr; v.pc = pc; v.bpt = bpt; v.wbe = wbe; v.wrd = wrd; v.wval = wval; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare(input exp_t e);
        chk("valid",     32'(valid_out),     32'(e.valid));
        chk("rd_write",  32'(rd_write_out),  32'(e.rdw));
        chk("mem_read",  32'(mem_read_out),  32'(e.mr));
        chk("mem_write", 32'(mem_write_out), 32'(e.mw));
        chk("illegal",   32'(illegal_out),   32'(e.ill));
        chk("branch_op", 32'(branch_op_out), 32'(e.bop));
        if (!e.bubble) begin
            chk("pc",        pc_out,                               e.pc);
            chk("bpt",       32'(branch_predicted_taken_out),      32'(e.bpt));
            chk("rs1",       32'(rs1_out),                         32'(e.rs1));
            chk("rs2",       32'(rs2_out),                         32'(e.rs2));
            chk("rd",        32'(rd_out),                          32'(e.rd));
            chk("rs1_value", rs1_value_out,                        e.rs1v);
            chk("rs2_value", rs2_value_out,                        e.rs2v);
            if (e.mr || e.mw) begin
                chk("mem_width", 32'(mem_width_out),       32'(e.wid));
                chk("mem_zext",  32'(mem_zero_extend_out), 32'(e.zx));
            end
            if (e.chk_imm) chk("imm", imm_value_out, e.imm);
            if (e.chk_alu) begin
                chk("alu_op",   32'(alu_op_out),   32'(e.alu));
                chk("alu_src1", 32'(alu_src1_out), 32'(e.s1));
                chk("alu_src2", 32'(alu_src2_out), 32'(e.s2));
            end
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic bpt,
                         input logic stall, input logic flush, input logic wbe,
                         input logic [4:0] wrd, input logic [31:0] wval, input exp_t e);
        instr_in = instr; pc_in = pc; branch_predicted_taken_in = bpt;
        stall_in = stall; flush_in = flush;
        rd_write_in = wbe; rd_in = wrd; rd_value_in = wval;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_asrt++;
            n_fail++;
            $display("FAIL scoreboard: output cycle with no expectation queued");
        end else begin
            compare(sb.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e, lw_e, rst_e;

        rst_e = '{default: '0};
        rst_e.chk_imm = 1'b1;
        rst_e.chk_alu = 1'b1;

        // Preload x6, x2, x31 under NOPs (x5 is written by the ADD entry).
        e = dec(32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b1, 1'b0);
        add(32'h00000013, 32'h0, 1'b0, 1'b1, 5'd6, 32'h66, e);
        e.pc = 32'h4;
        add(32'h00000013, 32'h4, 1'b0, 1'b1, 5'd2, 32'h40, e);
        e.pc = 32'h8;
        add(32'h00000013, 32'h8, 1'b0, 1'b1, 5'd31, 32'h3131, e);
        // ADD x1,x5,x6 with x5 written in the same cycle
        e = dec(32'h10, 1'b0, 5'd5, 5'd6, 5'd1, 32'hDEADBEEF, 32'h66, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b1);
        e.chk_imm = 1'b0;
        add(32'h006280B3, 32'h10, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, e);
        // BEQ x0,x0,-8 predicted taken
        e = dec(32'h20, 1'b1, 5'd0, 5'd0, 5'd25, 32'h0, 32'h0, 32'hFFFFFFF8, ALU_SUB, 1'b0, 1'b0, 1'b0);
        e.bop = BR_ZERO;
        add(32'hFE000CE3, 32'h20, 1'b1, 1'b0, 5'd0, 32'h0, e);
        // SUB x3,x5,x6
        e = dec(32'h24, 1'b0, 5'd5, 5'd6, 5'd3, 32'hDEADBEEF, 32'h66, 32'h0, ALU_SUB, 1'b0, 1'b0, 1'b1);
        e.chk_imm = 1'b0;
        add(32'h406281B3, 32'h24, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // SRAI x4,x5,6
        e = dec(32'h28, 1'b0, 5'd5, 5'd6, 5'd4, 32'hDEADBEEF, 32'h66, 32'h406, ALU_SRA, 1'b0, 1'b1, 1'b1);
        add(32'h4062D213, 32'h28, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // ADDI x7,x0,-1 : instr[30]=1 must not turn into SUB
        e = dec(32'h2C, 1'b0, 5'd0, 5'd31, 5'd7, 32'h0, 32'h3131, 32'hFFFFFFFF, ALU_ADD, 1'b0, 1'b1, 1'b1);
        add(32'hFFF00393, 32'h2C, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // LUI x8,0x80000
        e = dec(32'h30, 1'b0, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h80000000, ALU_SRC2, 1'b0, 1'b1, 1'b1);
        add(32'h80000437, 32'h30, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // AUIPC x9,0x80000
        e = dec(32'h34, 1'b0, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h80000000, ALU_ADD, 1'b1, 1'b1, 1'b1);
        add(32'h80000497, 32'h34, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // LBU x10,-1(x2)
        e = dec(32'h38, 1'b0, 5'd2, 5'd31, 5'd10, 32'h40, 32'h3131, 32'hFFFFFFFF, ALU_ADD, 1'b0, 1'b1, 1'b1);
        e.mr = 1'b1; e.wid = MEM_BYTE; e.zx = 1'b1;
        add(32'hFFF14503, 32'h38, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // load with reserved funct3=3 -> illegal
        e = dec(32'h3C, 1'b0, 5'd2, 5'd0, 5'd7, 32'h40, 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b0);
        e.ill = 1'b1; e.chk_imm = 1'b0; e.chk_alu = 1'b0;
        add(32'h00013383, 32'h3C, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // JAL x1,+0x1000
        e = dec(32'h40, 1'b0, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h1000, ALU_ADD, 1'b1, 1'b1, 1'b1);
        e.bop = BR_ALWAYS;
        add(32'h000010EF, 32'h40, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // all-ones word is illegal; also try to write x0 = 5
        e = dec(32'h44, 1'b0, 5'd31, 5'd31, 5'd31, 32'h3131, 32'h3131, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b0);
        e.ill = 1'b1; e.chk_imm = 1'b0; e.chk_alu = 1'b0;
        add(32'hFFFFFFFF, 32'h44, 1'b0, 1'b1, 5'd0, 32'h5, e);
        // ADD x11,x0,x0 : x0 still reads 0
        e = dec(32'h48, 1'b0, 5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b1);
        e.chk_imm = 1'b0;
        add(32'h000005B3, 32'h48, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // OR x12,x5,x6
        e = dec(32'h4C, 1'b0, 5'd5, 5'd6, 5'd12, 32'hDEADBEEF, 32'h66, 32'h0, ALU_OR, 1'b0, 1'b0, 1'b1);
        e.chk_imm = 1'b0;
        add(32'h0062E633, 32'h4C, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // BLTU x5,x6,+8
        e = dec(32'h50, 1'b0, 5'd5, 5'd6, 5'd8, 32'hDEADBEEF, 32'h66, 32'h8, ALU_SLTU, 1'b0, 1'b0, 1'b0);
        e.bop = BR_NON_ZERO;
        add(32'h0062E463, 32'h50, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // ECALL : valid NOP
        e = dec(32'h54, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b0);
        e.chk_imm = 1'b0; e.chk_alu = 1'b0;
        add(32'h00000073, 32'h54, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // low bits != 2'b11 -> illegal
        e.pc = 32'h58; e.ill = 1'b1;
        add(32'h00000011, 32'h58, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // JALR x1,0x40(x5)
        e = dec(32'h5C, 1'b0, 5'd5, 5'd0, 5'd1, 32'hDEADBEEF, 32'h0, 32'h40, ALU_ADD, 1'b0, 1'b1, 1'b1);
        e.bop = BR_ALWAYS;
        add(32'h040280E7, 32'h5C, 1'b0, 1'b0, 5'd0, 32'h0, e);

        // Reset: two edges, then check the reset state.
        reset = 1'b1;
        drive(32'h00000013, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, rst_e);
        tick();
        drive(32'h00000013, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, rst_e);
        tick();
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].instr, tbl[i].pc, tbl[i].bpt, 1'b0, 1'b0,
                  tbl[i].wbe, tbl[i].wrd, tbl[i].wval, tbl[i].e);
            tick();
        end

        // LW x7,0(x2) then three stalled cycles; x2 is rewritten mid-stall,
        // an unrelated register and x0 are written on the later stall cycles.
        lw_e = dec(32'h200, 1'b0, 5'd2, 5'd0, 5'd7, 32'h40, 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b1, 1'b1);
        lw_e.mr = 1'b1; lw_e.wid = MEM_WORD;
        drive(32'h00012383, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, lw_e);
        tick();
        lw_e.rs1v = 32'h100;
        drive(32'h00000013, 32'h300, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 32'h100, lw_e);
        tick();
        drive(32'h00000013, 32'h304, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h999, lw_e);
        tick();
        drive(32'h00000013, 32'h308, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 32'h77, lw_e);
        tick();

        // SW x5,4(x2), then flush together with stall squashes it.
        e = dec(32'h204, 1'b0, 5'd2, 5'd5, 5'd4, 32'h100, 32'hDEADBEEF, 32'h4, ALU_ADD, 1'b0, 1'b1, 1'b0);
        e.mw = 1'b1; e.wid = MEM_WORD;
        drive(32'h00512223, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, e);
        tick();
        e = '{default: '0};
        e.bubble = 1'b1;
        drive(32'h006280B3, 32'h208, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, e);
        tick();

        // Recover, then a plain flush (no stall) over a valid load.
        lw_e.pc = 32'h20C;
        drive(32'h00012383, 32'h20C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, lw_e);
        tick();
        drive(32'h00012383, 32'h210, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, e);
        tick();

        if (sb.size() != 0) begin
            n_asrt++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
